// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional feature: define MULDIV_FAST_MUL_EN for a single-cycle multiply.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic               op_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign op_signed = ~op[0] & ~op[2];
  assign mag_a     = (op_signed && A[WIDTH-1]) ? neg_w(A) : A;
  assign mag_b     = (op_signed && B[WIDTH-1]) ? neg_w(B) : B;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide: {remainder, dividend/quotient} shifts left one bit per step.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] sa_ext, sb_ext, s_prod;
  logic [2*WIDTH-1:0]        u_prod;
  assign sa_ext = {{WIDTH{A[WIDTH-1]}}, A};
  assign sb_ext = {{WIDTH{B[WIDTH-1]}}, B};
  assign s_prod = sa_ext * sb_ext;
  assign u_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = op_signed ? s_prod : u_prod;
              state_d      = S_DONE;
`else
              acc_d     = {{WIDTH{1'b0}}, mag_b};
              opnd_d    = mag_a;
              is_div_d  = 1'b0;
              neg_res_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d = 1'b0;
              cnt_d     = CNT_W'(WIDTH);
              state_d   = S_MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (B == '0) begin
                dz_d    = 1'b1;
                state_d = S_DONE;
              end else begin
                acc_d     = {{WIDTH{1'b0}}, mag_a};
                opnd_d    = mag_b;
                is_div_d  = 1'b1;
                neg_res_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_rem_d = op_signed & A[WIDTH-1];
                cnt_d     = CNT_W'(WIDTH);
                state_d   = S_DIV;
              end
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            lo_d = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = neg_res_q ? neg_2w(acc_q) : acc_q;
          end
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int DIV_LAT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 0;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = W + 1;
  localparam int MUL_BUSY = W + 1;
`endif

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] A = '0, B = '0;
  logic         cancel = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
    .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         dz;
    int           lat;
    int           bcnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one op; returns edges after the accept edge until done, and busy-cycle count.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n, output int bcnt, output logic dz);
    @(negedge CLK);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0; bcnt = 0;
    while (!done && n < 200) begin
      if (busy) bcnt++;
      @(posedge CLK); #1;
      n++;
    end
    dz = div_zero;
  endtask

  task automatic pulse(input logic [2:0] o, input logic [W-1:0] a, input logic c);
    @(negedge CLK);
    start = 1'b1; op = o; A = a; B = '0; cancel = c;
    @(posedge CLK); #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    int n, bc, seen;
    logic dz;
    logic [W-1:0] hold_hi, hold_lo;

    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, MUL_LAT, MUL_BUSY};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT, MUL_BUSY};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT, DIV_LAT};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, DIV_LAT, DIV_LAT};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT, DIV_LAT};
    vecs[5]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, MUL_LAT, MUL_BUSY};
    vecs[6]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, MUL_LAT, MUL_BUSY};
    vecs[7]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT, MUL_BUSY};
    vecs[8]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT, DIV_LAT};
    vecs[9]  = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, DIV_LAT, DIV_LAT};
    vecs[10] = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, DIV_LAT, DIV_LAT};
    vecs[11] = '{3'b011, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, DIV_LAT, DIV_LAT};

    // Reset state
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk("rst_hi", {32'd0, HI}, 64'd0);
    chk("rst_lo", {32'd0, LO}, 64'd0);
    @(negedge CLK); RST_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n, bc, dz);
      chk($sformatf("v%0d_lat", i), 64'(n), 64'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(bc), 64'(vecs[i].bcnt));
      chk($sformatf("v%0d_hi", i), {32'd0, HI}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, LO}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
      @(posedge CLK); #1;
      chk($sformatf("v%0d_done_1cyc", i), {63'd0, done}, 64'd0);
    end

    // MTLO/MTHI then divide by zero
    pulse(3'b101, 32'h0BADF00D, 1'b0);
    chk("mtlo_lo", {32'd0, LO}, {32'd0, 32'h0BADF00D});
    pulse(3'b100, 32'h12345678, 1'b0);
    chk("mthi_hi", {32'd0, HI}, {32'd0, 32'h12345678});
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    chk("mthi_done", {63'd0, done}, 64'd0);
    run_op(3'b011, 32'd5, 32'd0, n, bc, dz);
    chk("dz_lat", 64'(n), 64'd0);
    chk("dz_busy", 64'(bc), 64'd0);
    chk("dz_flag", {63'd0, dz}, 64'd1);
    chk("dz_hi", {32'd0, HI}, {32'd0, 32'h12345678});
    chk("dz_lo", {32'd0, LO}, {32'd0, 32'h0BADF00D});
    @(posedge CLK); #1;
    chk("dz_done_1cyc", {63'd0, done}, 64'd0);
    chk("dz_flag_1cyc", {63'd0, div_zero}, 64'd0);

    // start together with cancel in IDLE is dropped
    pulse(3'b100, 32'hDEADBEEF, 1'b1);
    chk("cancel_start_hi", {32'd0, HI}, {32'd0, 32'h12345678});

    // Cancel a divide at iteration 10
    @(negedge CLK);
    start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7;
    @(posedge CLK); #1; start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK); cancel = 1'b1;
    @(posedge CLK); #1; cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (done || busy) seen++;
    end
    chk("cancel_no_done", 64'(seen), 64'd0);
    chk("cancel_hi", {32'd0, HI}, {32'd0, 32'h12345678});
    chk("cancel_lo", {32'd0, LO}, {32'd0, 32'h0BADF00D});

    // start while busy is ignored
    @(negedge CLK);
    start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7;
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    start = 1'b1; op = 3'b001; A = 32'd3; B = 32'd5;
    @(posedge CLK); #1; start = 1'b0;
    n = 6;
    while (!done && n < 200) begin @(posedge CLK); #1; n++; end
    chk("ign_lat", 64'(n), 64'(DIV_LAT));
    chk("ign_hi", {32'd0, HI}, 64'd2);
    chk("ign_lo", {32'd0, LO}, 64'd14);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (busy) seen++;
    end
    chk("ign_no_queue", 64'(seen), 64'd0);

    // Asynchronous reset mid-operation
    @(negedge CLK);
    start = 1'b1; A = 32'hFFFFFFFF; B = 32'd2;
`ifdef MULDIV_FAST_MUL_EN
    op = 3'b011;
`else
    op = 3'b001;
`endif
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) @(posedge CLK);
    #3; RST_N = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hi", {32'd0, HI}, 64'd0);
    chk("arst_lo", {32'd0, LO}, 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    pulse(3'b101, 32'hA5A5A5A5, 1'b0);
    chk("post_rst_mtlo", {32'd0, LO}, {32'd0, 32'hA5A5A5A5});
    chk("post_rst_hi", {32'd0, HI}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
